// File: rtl/game_timer.sv
// ----------------------------------------------------------------------------
// game_timer
//   Round countdown timer for the game state machine. A rising edge on
//   game_on loads START_MIN:START_SEC and counts down once per second as BCD
//   M:SS digits. Supports pause, bonus-time pickups and a sticky expiry flag.
//
// Ports
//   clk            system clock
//   resetN         asynchronous active-low reset
//   game_on        round active level (rising edge starts a round)
//   pause          level; freezes prescaler and digits while high
//   bonus_pulse    one-cycle pulse; adds BONUS_SEC (RUNNING only)
//   timer_ended    sticky expiry flag, set on the edge that reaches 0:00
//   minutes        BCD minutes digit
//   sec_tens       BCD tens-of-seconds digit (0..5)
//   sec_ones       BCD ones-of-seconds digit
//   one_sec_pulse  one-cycle pulse on every countdown decrement
//   warning        low-time indicator (RUNNING/PAUSED, total <= WARN_SEC)
// All outputs are registered.
// ----------------------------------------------------------------------------
module game_timer #(
   parameter int unsigned TICKS_PER_SEC = 31500000,
   parameter int unsigned START_MIN     = 3,
   parameter int unsigned START_SEC     = 0,
   parameter int unsigned BONUS_SEC     = 15,
   parameter int unsigned WARN_SEC      = 30
) (
   input  logic       clk,
   input  logic       resetN,
   input  logic       game_on,
   input  logic       pause,
   input  logic       bonus_pulse,
   output logic       timer_ended,
   output logic [3:0] minutes,
   output logic [3:0] sec_tens,
   output logic [3:0] sec_ones,
   output logic       one_sec_pulse,
   output logic       warning
);

   localparam int unsigned PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
   localparam logic [PW-1:0] PRE_LAST = PW'(TICKS_PER_SEC - 1);
   localparam logic [PW-1:0] PRE_ONE  = PW'(1);
   localparam logic [3:0]    START_M  = 4'(START_MIN);
   localparam logic [3:0]    START_T  = 4'(START_SEC / 10);
   localparam logic [3:0]    START_O  = 4'(START_SEC % 10);
   localparam logic [6:0]    BONUS7   = 7'(BONUS_SEC);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RUNNING = 2'd1,
      PAUSED  = 2'd2,
      EXPIRED = 2'd3
   } state_t;

   state_t        state_q, state_d;
   logic          game_on_q;
   logic [PW-1:0] pre_q, pre_d;
   logic [3:0]    min_q, min_d, tens_q, tens_d, ones_q, ones_d;
   logic          ended_q, ended_d;
   logic          pulse_q, pulse_d;
   logic          warn_q, warn_d;

   logic          start;
   logic          tick;
   logic [3:0]    dec_m, dec_t, dec_o;
   logic          dec_zero;
   logic [3:0]    cur_m, cur_t, cur_o;
   logic [6:0]    sec_sum, sec_adj;
   logic          sec_carry;
   logic [3:0]    bon_m, bon_t, bon_o;
   logic [31:0]   total_d;

   assign start = game_on & ~game_on_q;
   assign tick  = (pre_q == PRE_LAST);

   // ------------------------------------------------------------------------
   // One-second BCD decrement with borrow: ones 0->9 borrows from tens,
   // tens 0->5 borrows from minutes.
   // ------------------------------------------------------------------------
   always_comb begin
      dec_m = min_q;
      dec_t = tens_q;
      dec_o = ones_q;
      if (ones_q != 4'd0) begin
         dec_o = ones_q - 4'd1;
      end else begin
         dec_o = 4'd9;
         if (tens_q != 4'd0) begin
            dec_t = tens_q - 4'd1;
         end else begin
            dec_t = 4'd5;
            dec_m = min_q - 4'd1;
         end
      end
   end

   assign dec_zero = (dec_m == 4'd0) && (dec_t == 4'd0) && (dec_o == 4'd0);

   // Bonus is applied on top of this cycle's decrement, so a tick at 0:01
   // with a coinciding bonus lands on BONUS_SEC instead of expiring.
   assign cur_m = tick ? dec_m : min_q;
   assign cur_t = tick ? dec_t : tens_q;
   assign cur_o = tick ? dec_o : ones_q;

   // ------------------------------------------------------------------------
   // Bonus add: seconds in binary, wrap at 60 into minutes, saturate at 9:59.
   // ------------------------------------------------------------------------
   always_comb begin
      sec_sum   = 7'(cur_t) * 7'd10 + 7'(cur_o) + BONUS7;
      sec_carry = (sec_sum >= 7'd60);
      sec_adj   = sec_carry ? (sec_sum - 7'd60) : sec_sum;
      bon_m     = cur_m;
      bon_t     = 4'(sec_adj / 7'd10);
      bon_o     = 4'(sec_adj % 7'd10);
      if (sec_carry) begin
         if (cur_m >= 4'd9) begin
            bon_m = 4'd9;
            bon_t = 4'd5;
            bon_o = 4'd9;
         end else begin
            bon_m = cur_m + 4'd1;
         end
      end
   end

   // ------------------------------------------------------------------------
   // Next-state and datapath
   // ------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      pre_d   = pre_q;
      min_d   = min_q;
      tens_d  = tens_q;
      ones_d  = ones_q;
      ended_d = ended_q;
      pulse_d = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (start) begin
               state_d = RUNNING;
               pre_d   = '0;
               min_d   = START_M;
               tens_d  = START_T;
               ones_d  = START_O;
               ended_d = 1'b0;
            end
         end

         RUNNING: begin
            if (!game_on) begin
               // Round stopped elsewhere: freeze the display, drop any tick.
               state_d = IDLE;
            end else begin
               pre_d   = tick ? '0 : (pre_q + PRE_ONE);
               pulse_d = tick;
               if (bonus_pulse) begin
                  min_d  = bon_m;
                  tens_d = bon_t;
                  ones_d = bon_o;
               end else begin
                  min_d  = cur_m;
                  tens_d = cur_t;
                  ones_d = cur_o;
               end
               if (tick && dec_zero && !bonus_pulse) begin
                  state_d = EXPIRED;
                  ended_d = 1'b1;
               end else if (pause) begin
                  state_d = PAUSED;
               end
            end
         end

         PAUSED: begin
            if (!game_on) begin
               state_d = IDLE;
            end else if (!pause) begin
               state_d = RUNNING;
            end
         end

         EXPIRED: begin
            // game_on falling is ignored here; only a new start leaves.
            ended_d = 1'b1;
            min_d   = '0;
            tens_d  = '0;
            ones_d  = '0;
            if (start) begin
               state_d = RUNNING;
               pre_d   = '0;
               min_d   = START_M;
               tens_d  = START_T;
               ones_d  = START_O;
               ended_d = 1'b0;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Warning looks at the post-update value so it tracks the displayed digits.
   always_comb begin
      total_d = 32'(min_d) * 32'd60 + 32'(tens_d) * 32'd10 + 32'(ones_d);
      warn_d  = ((state_d == RUNNING) || (state_d == PAUSED)) &&
                (total_d <= WARN_SEC);
   end

   // ------------------------------------------------------------------------
   // Registers
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         state_q   <= IDLE;
         game_on_q <= 1'b0;
         pre_q     <= '0;
         min_q     <= START_M;
         tens_q    <= START_T;
         ones_q    <= START_O;
         ended_q   <= 1'b0;
         pulse_q   <= 1'b0;
         warn_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         game_on_q <= game_on;
         pre_q     <= pre_d;
         min_q     <= min_d;
         tens_q    <= tens_d;
         ones_q    <= ones_d;
         ended_q   <= ended_d;
         pulse_q   <= pulse_d;
         warn_q    <= warn_d;
      end
   end

   assign timer_ended   = ended_q;
   assign minutes       = min_q;
   assign sec_tens      = tens_q;
   assign sec_ones      = ones_q;
   assign one_sec_pulse = pulse_q;
   assign warning       = warn_q;

endmodule

// File: tb/tb_game_timer.sv
// ----------------------------------------------------------------------------
// tb_game_timer
//   Four game_timer instances (TICKS_PER_SEC=4) with different start values:
//     0: START 0:03  countdown/expiry, tick+bonus at 0:01, async reset
//     1: START 1:00  borrow, pause hold/resume, bonus in PAUSED, warning edge
//     2: START 9:50  bonus saturation
//     3: START 3:00  stop at 1:37 and reload
//   Inputs change at posedge+1; outputs are checked at posedge+1.
// ----------------------------------------------------------------------------
module tb_game_timer;

   logic clk = 1'b0;
   logic resetN;
   logic [3:0] go, pz, bp;
   logic [3:0] te, op, wn;
   logic [3:0][3:0] mn, st, so;

   int total  = 0;
   int passed = 0;

   always #5 clk = ~clk;

   game_timer #(.TICKS_PER_SEC(4), .START_MIN(0), .START_SEC(3),
                .BONUS_SEC(15), .WARN_SEC(30)) u_a (
      .clk(clk), .resetN(resetN), .game_on(go[0]), .pause(pz[0]),
      .bonus_pulse(bp[0]), .timer_ended(te[0]), .minutes(mn[0]),
      .sec_tens(st[0]), .sec_ones(so[0]), .one_sec_pulse(op[0]),
      .warning(wn[0]));

   game_timer #(.TICKS_PER_SEC(4), .START_MIN(1), .START_SEC(0),
                .BONUS_SEC(15), .WARN_SEC(30)) u_b (
      .clk(clk), .resetN(resetN), .game_on(go[1]), .pause(pz[1]),
      .bonus_pulse(bp[1]), .timer_ended(te[1]), .minutes(mn[1]),
      .sec_tens(st[1]), .sec_ones(so[1]), .one_sec_pulse(op[1]),
      .warning(wn[1]));

   game_timer #(.TICKS_PER_SEC(4), .START_MIN(9), .START_SEC(50),
                .BONUS_SEC(15), .WARN_SEC(30)) u_c (
      .clk(clk), .resetN(resetN), .game_on(go[2]), .pause(pz[2]),
      .bonus_pulse(bp[2]), .timer_ended(te[2]), .minutes(mn[2]),
      .sec_tens(st[2]), .sec_ones(so[2]), .one_sec_pulse(op[2]),
      .warning(wn[2]));

   game_timer #(.TICKS_PER_SEC(4), .START_MIN(3), .START_SEC(0),
                .BONUS_SEC(15), .WARN_SEC(30)) u_d (
      .clk(clk), .resetN(resetN), .game_on(go[3]), .pause(pz[3]),
      .bonus_pulse(bp[3]), .timer_ended(te[3]), .minutes(mn[3]),
      .sec_tens(st[3]), .sec_ones(so[3]), .one_sec_pulse(op[3]),
      .warning(wn[3]));

   typedef struct {
      logic       go, pz, bp;
      logic       te;
      logic [3:0] m, t, o;
      logic       p, w;
   } vec_t;

   vec_t tbl[32];

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic run(input int n);
      for (int k = 0; k < n; k++) cyc();
   endtask

   task automatic chk(input string name, input int i, input logic e_te,
                      input logic [3:0] e_m, input logic [3:0] e_t,
                      input logic [3:0] e_o, input logic e_p, input logic e_w);
      logic [14:0] got, exp;
      got = {te[i], mn[i], st[i], so[i], op[i], wn[i]};
      exp = {e_te, e_m, e_t, e_o, e_p, e_w};
      total++;
      if (got === exp) passed++;
      else $display("FAIL %s: got ended=%0b %0h:%0h%0h pulse=%0b warn=%0b, want ended=%0b %0h:%0h%0h pulse=%0b warn=%0b",
                    name, te[i], mn[i], st[i], so[i], op[i], wn[i],
                    e_te, e_m, e_t, e_o, e_p, e_w);
   endtask

   initial begin
      // {go, pz, bp, ended, M, T, O, pulse, warn} for instance 0 per cycle
      tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd3, 1'b0, 1'b1};
      tbl[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd3, 1'b0, 1'b1};
      tbl[2]  = '{1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd3, 1'b0, 1'b1};
      tbl[3]  = '{1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd3, 1'b0, 1'b1};
      tbl[4]  = '{1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd2, 1'b1, 1'b1};
      tbl[5]  = '{1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd2, 1'b0, 1'b1};
      tbl[6]  = '{1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd2, 1'b0, 1'b1};
      tbl[7]  = '{1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd2, 1'b0, 1'b1};
      tbl[8]  = '{1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd1, 1'b1, 1'b1};
      tbl[9]  = '{1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd1, 1'b0, 1'b1};
      tbl[10] = '{1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd1, 1'b0, 1'b1};
      tbl[11] = '{1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd1, 1'b0, 1'b1};
      tbl[12] = '{1'b1, 1'b0, 1'b0, 1'b1, 4'd0, 4'd0, 4'd0, 1'b1, 1'b0};
      tbl[13] = '{1'b1, 1'b0, 1'b0, 1'b1, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0};
      tbl[14] = '{1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0};
      tbl[15] = '{1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0};
      tbl[16] = '{1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd3, 1'b0, 1'b1};
      tbl[17] = '{1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd3, 1'b0, 1'b1};
      tbl[18] = '{1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd3, 1'b0, 1'b1};
      tbl[19] = '{1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd3, 1'b0, 1'b1};
      tbl[20] = '{1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd2, 1'b1, 1'b1};
      tbl[21] = '{1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd2, 1'b0, 1'b1};
      tbl[22] = '{1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd2, 1'b0, 1'b1};
      tbl[23] = '{1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd2, 1'b0, 1'b1};
      tbl[24] = '{1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd1, 1'b1, 1'b1};
      tbl[25] = '{1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd1, 1'b0, 1'b1};
      tbl[26] = '{1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd1, 1'b0, 1'b1};
      tbl[27] = '{1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd1, 1'b0, 1'b1};
      tbl[28] = '{1'b1, 1'b0, 1'b1, 1'b0, 4'd0, 4'd1, 4'd5, 1'b1, 1'b1};
      tbl[29] = '{1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 4'd1, 4'd5, 1'b0, 1'b1};
      tbl[30] = '{1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd1, 4'd5, 1'b0, 1'b0};
      tbl[31] = '{1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 4'd1, 4'd5, 1'b0, 1'b0};

      resetN = 1'b0;
      go = '0;
      pz = '0;
      bp = '0;
      #12 resetN = 1'b1;
      cyc();
      chk("reset_a", 0, 1'b0, 4'd0, 4'd0, 4'd3, 1'b0, 1'b0);
      chk("reset_b", 1, 1'b0, 4'd1, 4'd0, 4'd0, 1'b0, 1'b0);
      chk("reset_c", 2, 1'b0, 4'd9, 4'd5, 4'd0, 1'b0, 1'b0);
      chk("reset_d", 3, 1'b0, 4'd3, 4'd0, 4'd0, 1'b0, 1'b0);

      // Countdown to expiry, restart from EXPIRED, tick+bonus at 0:01, stop.
      for (int k = 0; k < 32; k++) begin
         go[0] = tbl[k].go;
         pz[0] = tbl[k].pz;
         bp[0] = tbl[k].bp;
         cyc();
         chk($sformatf("vec%0d", k), 0, tbl[k].te, tbl[k].m, tbl[k].t,
             tbl[k].o, tbl[k].p, tbl[k].w);
      end
      bp[0] = 1'b0;

      // Instance 1: borrow, pause with bonus inside, resume timing, warning.
      go[1] = 1'b1;
      cyc();                                        // edge 0
      chk("b_start", 1, 1'b0, 4'd1, 4'd0, 4'd0, 1'b0, 1'b0);
      run(3);
      cyc();                                        // edge 4
      chk("b_borrow", 1, 1'b0, 4'd0, 4'd5, 4'd9, 1'b1, 1'b0);
      cyc();                                        // edge 5
      pz[1] = 1'b1;
      cyc();                                        // edge 6, prescaler held at 2
      chk("b_pause_in", 1, 1'b0, 4'd0, 4'd5, 4'd9, 1'b0, 1'b0);
      for (int k = 7; k <= 15; k++) begin
         bp[1] = (k == 10);
         cyc();
         chk($sformatf("b_paused%0d", k), 1, 1'b0, 4'd0, 4'd5, 4'd9, 1'b0, 1'b0);
      end
      bp[1] = 1'b0;
      pz[1] = 1'b0;
      cyc();                                        // edge 16, resume
      chk("b_resume", 1, 1'b0, 4'd0, 4'd5, 4'd9, 1'b0, 1'b0);
      cyc();                                        // edge 17
      chk("b_resume1", 1, 1'b0, 4'd0, 4'd5, 4'd9, 1'b0, 1'b0);
      cyc();                                        // edge 18
      chk("b_tick_after_pause", 1, 1'b0, 4'd0, 4'd5, 4'd8, 1'b1, 1'b0);
      run(31);
      cyc();                                        // edge 50
      chk("b_at_050", 1, 1'b0, 4'd0, 4'd5, 4'd0, 1'b1, 1'b0);
      bp[1] = 1'b1;
      cyc();                                        // edge 51
      bp[1] = 1'b0;
      chk("b_bonus_carry", 1, 1'b0, 4'd1, 4'd0, 4'd5, 1'b0, 1'b0);
      run(137);
      cyc();                                        // edge 189
      chk("b_at_031", 1, 1'b0, 4'd0, 4'd3, 4'd1, 1'b0, 1'b0);
      cyc();                                        // edge 190
      chk("b_warn_030", 1, 1'b0, 4'd0, 4'd3, 4'd0, 1'b1, 1'b1);
      go[1] = 1'b0;
      cyc();
      chk("b_idle", 1, 1'b0, 4'd0, 4'd3, 4'd0, 1'b0, 1'b0);

      // Instance 2: bonus saturation.
      go[2] = 1'b1;
      cyc();
      chk("c_start", 2, 1'b0, 4'd9, 4'd5, 4'd0, 1'b0, 1'b0);
      bp[2] = 1'b1;
      cyc();
      bp[2] = 1'b0;
      chk("c_saturate", 2, 1'b0, 4'd9, 4'd5, 4'd9, 1'b0, 1'b0);
      go[2] = 1'b0;
      cyc();

      // Instance 3: stop at 1:37, hold, reload 3:00.
      go[3] = 1'b1;
      cyc();
      chk("d_start", 3, 1'b0, 4'd3, 4'd0, 4'd0, 1'b0, 1'b0);
      run(331);
      cyc();                                        // edge 332
      chk("d_at_137", 3, 1'b0, 4'd1, 4'd3, 4'd7, 1'b1, 1'b0);
      go[3] = 1'b0;
      cyc();
      chk("d_stop", 3, 1'b0, 4'd1, 4'd3, 4'd7, 1'b0, 1'b0);
      run(2);
      chk("d_hold", 3, 1'b0, 4'd1, 4'd3, 4'd7, 1'b0, 1'b0);
      go[3] = 1'b1;
      cyc();
      chk("d_reload", 3, 1'b0, 4'd3, 4'd0, 4'd0, 1'b0, 1'b0);
      go[3] = 1'b0;
      cyc();

      // Instance 0: reset at 0:01, no expiry afterwards.
      go[0] = 1'b1;
      cyc();                                        // edge 0
      run(7);
      cyc();                                        // edge 8
      chk("a_at_001", 0, 1'b0, 4'd0, 4'd0, 4'd1, 1'b1, 1'b1);
      cyc();                                        // edge 9
      #2 resetN = 1'b0;
      #1;
      chk("a_reset_async", 0, 1'b0, 4'd0, 4'd0, 4'd3, 1'b0, 1'b0);
      go[0] = 1'b0;
      cyc();
      chk("a_in_reset", 0, 1'b0, 4'd0, 4'd0, 4'd3, 1'b0, 1'b0);
      resetN = 1'b1;
      for (int k = 0; k < 12; k++) begin
         cyc();
         chk($sformatf("a_post_reset%0d", k), 0, 1'b0, 4'd0, 4'd0, 4'd3, 1'b0, 1'b0);
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
